// File: rtl/bitstream_packer_pkg.sv
// Shared definitions for the bitstream packer: default widths, flush state
// encoding and the JPEG marker/stuff byte values.
package bitstream_packer_pkg;

    localparam int IN_W_DEFAULT  = 32;
    localparam int LEN_W_DEFAULT = 6;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        PAD   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [7:0] STUFF_BYTE  = 8'h00;
    localparam logic [7:0] MARKER_BYTE = 8'hFF;

endpackage

// File: rtl/bitstream_packer.sv
// Packs variable-length MSB-first codes into a byte stream with flush/pad.
// Optional JPEG_BYTE_STUFF_EN inserts 8'h00 after every emitted 8'hFF.
module bitstream_packer
    import bitstream_packer_pkg::*;
#(
    parameter int IN_W  = IN_W_DEFAULT,
    parameter int LEN_W = LEN_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [LEN_W-1:0] in_len,
    input  logic [IN_W-1:0]  in_data,
    output logic             in_ready,
    input  logic             flush,
    output logic             flush_done,
    output logic [7:0]       out_byte,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int ACC_W = 2 * IN_W;
    localparam int CNT_W = $clog2(ACC_W + 1);

    // Valid bits are kept left-aligned: the oldest bit sits at acc_reg[ACC_W-1].
    logic [ACC_W-1:0] acc_reg;
    logic [CNT_W-1:0] cnt_reg;
    state_t           state_reg;
    logic [7:0]       out_byte_reg;
    logic             out_valid_reg;
    logic             flush_done_reg;

    logic             accept;
    logic             out_free;
    logic             stuff_pending;
    logic             load;
    logic             load_data;
    logic [CNT_W-1:0] app_len_next;
    logic [ACC_W-1:0] app_bits_next;
    logic [ACC_W-1:0] app_masked_next;
    logic [CNT_W-1:0] cnt_app_next;
    logic [ACC_W-1:0] acc_app_next;

    assign in_ready   = (cnt_reg <= CNT_W'(IN_W)) && (state_reg == RUN);
    assign accept     = in_ready && (in_len != '0);
    assign out_free   = !out_valid_reg || out_ready;
    assign out_byte   = out_byte_reg;
    assign out_valid  = out_valid_reg;
    assign flush_done = flush_done_reg;

    // Input code and pad ones share one append path; they never coincide.
    always_comb begin
        app_len_next  = '0;
        app_bits_next = '0;
        if (accept) begin
            app_len_next  = CNT_W'(in_len);
            app_bits_next = ACC_W'(in_data);
        end else if (state_reg == PAD && cnt_reg[2:0] != 3'd0) begin
            app_len_next  = CNT_W'(4'd8 - {1'b0, cnt_reg[2:0]});
            app_bits_next = ACC_W'(8'hFF);
        end
    end

    assign app_masked_next = app_bits_next & ((ACC_W'(1) << app_len_next) - ACC_W'(1));
    assign cnt_app_next    = cnt_reg + app_len_next;
    assign acc_app_next    = acc_reg | (app_masked_next << (CNT_W'(ACC_W) - cnt_app_next));

    // A pending stuff byte always goes out before any further data byte.
    assign load      = out_free && (stuff_pending || (cnt_app_next >= CNT_W'(8)));
    assign load_data = load && !stuff_pending;

`ifdef JPEG_BYTE_STUFF_EN
    logic stuff_pending_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stuff_pending_reg <= 1'b0;
        end else if (load) begin
            stuff_pending_reg <= load_data && (acc_app_next[ACC_W-1 -: 8] == MARKER_BYTE);
        end
    end

    assign stuff_pending = stuff_pending_reg;
`else
    assign stuff_pending = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_reg        <= '0;
            cnt_reg        <= '0;
            state_reg      <= RUN;
            out_byte_reg   <= 8'h00;
            out_valid_reg  <= 1'b0;
            flush_done_reg <= 1'b0;
        end else begin
            acc_reg        <= load_data ? (acc_app_next << 8) : acc_app_next;
            cnt_reg        <= load_data ? (cnt_app_next - CNT_W'(8)) : cnt_app_next;
            out_valid_reg  <= load || (out_valid_reg && !out_ready);
            flush_done_reg <= 1'b0;
            if (load) begin
                out_byte_reg <= stuff_pending ? STUFF_BYTE : acc_app_next[ACC_W-1 -: 8];
            end
            case (state_reg)
                RUN: begin
                    if (flush) begin
                        state_reg <= PAD;
                    end
                end
                PAD: begin
                    state_reg <= DRAIN;
                end
                DRAIN: begin
                    if (cnt_reg == '0 && !stuff_pending && out_free) begin
                        flush_done_reg <= 1'b1;
                        state_reg      <= RUN;
                    end
                end
                default: begin
                    state_reg <= RUN;
                end
            endcase
        end
    end

    in_ready_protocol: assert property (@(posedge clk) disable iff (rst)
        (in_len != '0) |-> in_ready);

    in_len_range: assert property (@(posedge clk) disable iff (rst)
        in_len <= LEN_W'(IN_W));

endmodule

// File: tb/tb_bitstream_packer.sv
// Scoreboard bench for bitstream_packer: a bit-queue reference model produces
// expected bytes; a negedge monitor pops and compares on each handshake.
module tb_bitstream_packer;

`ifdef JPEG_BYTE_STUFF_EN
    localparam bit STUFF = 1'b1;
`else
    localparam bit STUFF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  in_len;
    logic [31:0] in_data;
    logic        in_ready;
    logic        flush;
    logic        flush_done;
    logic [7:0]  out_byte;
    logic        out_valid;
    logic        out_ready;

    int          errors = 0;
    int          checks = 0;
    int          ready_mode = 0;
    bit          bitq[$];
    logic [7:0]  expq[$];
    bit          hold_valid = 1'b0;
    logic [7:0]  hold_byte = 8'h00;

    always #5 clk = ~clk;

    bitstream_packer #(.IN_W(32), .LEN_W(6)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_len     (in_len),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .flush      (flush),
        .flush_done (flush_done),
        .out_byte   (out_byte),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain bit FIFO in transmission order, cut into bytes.
    function automatic void model_bytes();
        logic [7:0] b;
        while (bitq.size() >= 8) begin
            b = 8'h00;
            for (int i = 0; i < 8; i++) b = {b[6:0], bitq.pop_front()};
            expq.push_back(b);
            if (STUFF && b == 8'hFF) expq.push_back(8'h00);
        end
    endfunction

    function automatic void model_push(input int len, input logic [31:0] data);
        for (int i = len - 1; i >= 0; i--) bitq.push_back(data[i]);
        model_bytes();
    endfunction

    function automatic void model_pad();
        while (bitq.size() % 8 != 0) bitq.push_back(1'b1);
        model_bytes();
    endfunction

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Monitor: one line per handshake, plus a stability check while stalled.
    always @(negedge clk) begin
        if (rst) begin
            hold_valid = 1'b0;
        end else begin
            if (hold_valid) begin
                chk("stall_valid", 64'(out_valid), 64'd1);
                chk("stall_byte", 64'(out_byte), 64'(hold_byte));
            end
            hold_valid = 1'b0;
            if (out_valid && out_ready) begin
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_byte: got %02h expected none at %0t", out_byte, $time);
                end else begin
                    $display("byte %02h at %0t", out_byte, $time);
                    chk("out_byte", 64'(out_byte), 64'(expq.pop_front()));
                end
            end else if (out_valid) begin
                hold_valid = 1'b1;
                hold_byte  = out_byte;
            end
        end
    end

    task automatic wait_ready();
        int n;
        n = 0;
        while (!in_ready && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!in_ready) chk("in_ready_timeout", 64'(in_ready), 64'd1);
    endtask

    task automatic drive_word(input int len, input logic [31:0] data);
        wait_ready();
        in_len  = 6'(len);
        in_data = data;
        model_push(len, data);
        @(posedge clk);
        #1;
        in_len = '0;
    endtask

    task automatic do_flush(input int len, input logic [31:0] data, input bit refire, input int exp_lat);
        int lat;
        if (len > 0) wait_ready();
        flush   = 1'b1;
        in_len  = 6'(len);
        in_data = data;
        if (len > 0) model_push(len, data);
        model_pad();
        @(posedge clk);
        #1;
        flush  = 1'b0;
        in_len = '0;
        lat    = -1;
        for (int k = 1; k <= 400; k++) begin
            flush = (k == 1) && refire;
            @(posedge clk);
            #1;
            flush = 1'b0;
            if (flush_done) begin
                lat = k;
                break;
            end
        end
        $display("flush len=%0d latency=%0d", len, lat);
        chk("flush_done_seen", 64'(lat > 0), 64'd1);
        if (exp_lat >= 0) chk("flush_latency", 64'(lat), 64'(exp_lat));
        chk("drained_queue", 64'(expq.size()), 64'd0);
        @(posedge clk);
        #1;
        chk("flush_done_pulse", 64'(flush_done), 64'd0);
        if (refire) begin
            for (int k = 0; k < 4; k++) begin
                @(posedge clk);
                #1;
                chk("no_refire_done", 64'(flush_done), 64'd0);
            end
        end
    endtask

    task automatic random_phase(input int cycles);
        int  bits;
        int  len;
        bit  low_seen;
        logic [31:0] d;
        ready_mode = 2;
        @(posedge clk);
        #1;
        bits     = 0;
        low_seen = 1'b0;
        for (int c = 0; c < 10 + cycles; c++) begin
            if (c == 10) begin
                chk("in_ready_dropped", 64'(low_seen), 64'd1);
                chk("stall_capacity", 64'(bits <= 72), 64'd1);
                ready_mode = 1;
            end
            if (in_ready) begin
                len = int'($urandom_range(1, 32));
                d   = $urandom;
                in_len  = 6'(len);
                in_data = d;
                model_push(len, d);
                if (c < 10) bits += len;
            end else begin
                in_len = '0;
                if (c < 10) low_seen = 1'b1;
            end
            @(posedge clk);
            #1;
            in_len = '0;
        end
        ready_mode = 0;
        do_flush(0, 32'h0, 1'b0, -1);
    endtask

    initial begin
        rst     = 1'b1;
        in_len  = '0;
        in_data = '0;
        flush   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_byte", 64'(out_byte), 64'd0);
        chk("rst_flush_done", 64'(flush_done), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        rst = 1'b0;
        @(posedge clk);
        #1;

        drive_word(16, 32'h0000ABCD);
        chk("first_byte_latency", 64'(out_valid), 64'd1);
        chk("first_byte_value", 64'(out_byte), 64'hAB);
        do_flush(0, 32'h0, 1'b0, -1);

        drive_word(16, 32'h0000FF12);
        do_flush(0, 32'h0, 1'b0, -1);
        drive_word(3, 32'h00000005);
        do_flush(0, 32'h0, 1'b0, -1);
        drive_word(4, 32'h0000000F);
        do_flush(0, 32'h0, 1'b0, -1);
        do_flush(0, 32'h0, 1'b0, 2);
        drive_word(7, 32'h0000003C);
        do_flush(12, 32'hFFFFFA5C, 1'b1, -1);

        for (int r = 0; r < 3; r++) random_phase(200);

        // Reset mid-stream: 28 bits with the sink stalled leaves cnt=20 and a full output.
        ready_mode = 2;
        @(posedge clk);
        #1;
        drive_word(28, 32'h0ABCDEF1);
        chk("pre_rst_out_valid", 64'(out_valid), 64'd1);
        #1;
        rst = 1'b1;
        bitq.delete();
        expq.delete();
        #1;
        chk("async_rst_out_valid", 64'(out_valid), 64'd0);
        chk("async_rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        ready_mode = 0;
        repeat (5) @(posedge clk);
        #1;
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);
        drive_word(8, 32'h0000005A);
        do_flush(0, 32'h0, 1'b0, -1);
        do_flush(0, 32'h0, 1'b0, 2);

        chk("final_queue_empty", 64'(expq.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation exceeded time limit at %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
